// File: rtl/sort4_engine_pkg.sv
// Shared definitions for the sequential bubble-sort stage.
package sort4_engine_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Bits needed to hold the worst-case swap count DEPTH*(DEPTH-1)/2.
    function automatic int unsigned swap_cnt_width(input int unsigned depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/sort4_engine_magnitude_cmp.sv
// Purely combinational unsigned magnitude comparator.
module magnitude_cmp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_a_lt_b,
    output logic             o_a_gt_b,
    output logic             o_a_eq_b
);

    // Three mutually exclusive relations of the unsigned operands.
    always_comb begin
        o_a_lt_b = (i_a < i_b);
        o_a_gt_b = (i_a > i_b);
        o_a_eq_b = (i_a == i_b);
    end

endmodule

// File: rtl/sort4_engine.sv
// Batch sorter: load DEPTH samples, bubble-sort in place with one comparator,
// then stream them out in ascending order.
module sort4_engine
    import sort4_engine_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_in_valid,
    input  logic [WIDTH-1:0]                  i_in_data,
    output logic                              o_in_ready,
    output logic                              o_out_valid,
    output logic [WIDTH-1:0]                  o_out_data,
    output logic                              o_out_last,
    input  logic                              i_out_ready,
    output logic                              o_busy,
    output logic [swap_cnt_width(DEPTH)-1:0]  o_swap_count
);

    localparam int unsigned IDX_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned SWAP_W = swap_cnt_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(DEPTH - 2);

    state_e              r_state;
    logic [WIDTH-1:0]    r_buf [DEPTH];
    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    r_rd_idx;
    logic [IDX_W-1:0]    r_j;
    logic [IDX_W-1:0]    r_pass;
    logic [SWAP_W-1:0]   r_swap_count;

    logic [IDX_W-1:0]    w_j_next;
    logic                w_gt;
    logic                w_sorting;

    assign w_j_next  = r_j + IDX_W'(1);
    assign w_sorting = (r_state == ST_SORT);

    // Single shared comparator; only "greater than" triggers a swap, which keeps the sort stable.
    magnitude_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .i_a      (r_buf[r_j]),
        .i_b      (r_buf[w_j_next]),
        .o_a_lt_b (),
        .o_a_gt_b (w_gt),
        .o_a_eq_b ()
    );

    // Sample storage: written on accepted input beats, swapped in place while sorting.
    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && i_in_valid) begin
            r_buf[r_wr_idx] <= i_in_data;
        end else if (w_sorting && w_gt) begin
            r_buf[r_j]      <= r_buf[w_j_next];
            r_buf[w_j_next] <= r_buf[r_j];
        end
    end

    // Control FSM with index and swap-counter bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_LOAD;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_j          <= '0;
            r_pass       <= '0;
            r_swap_count <= '0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (i_in_valid) begin
                        if (r_wr_idx == '0) begin
                            r_swap_count <= '0;
                        end
                        if (r_wr_idx == LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_j      <= '0;
                            r_pass   <= '0;
                            r_state  <= ST_SORT;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                        end
                    end
                end
                ST_SORT: begin
                    if (w_gt) begin
                        r_swap_count <= r_swap_count + SWAP_W'(1);
                    end
                    // Fixed number of passes regardless of data: no early exit.
                    if (r_j == LAST_J) begin
                        r_j <= '0;
                        if (r_pass == LAST_J) begin
                            r_rd_idx <= '0;
                            r_state  <= ST_DRAIN;
                        end else begin
                            r_pass <= r_pass + IDX_W'(1);
                        end
                    end else begin
                        r_j <= w_j_next;
                    end
                end
                ST_DRAIN: begin
                    if (i_out_ready) begin
                        if (r_rd_idx == LAST_IDX) begin
                            r_rd_idx <= '0;
                            r_state  <= ST_LOAD;
                        end else begin
                            r_rd_idx <= r_rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Outputs decode purely from registered state.
    always_comb begin
        o_in_ready   = (r_state == ST_LOAD);
        o_busy       = w_sorting;
        o_out_valid  = (r_state == ST_DRAIN);
        o_out_data   = o_out_valid ? r_buf[r_rd_idx] : '0;
        o_out_last   = o_out_valid && (r_rd_idx == LAST_IDX);
        o_swap_count = r_swap_count;
    end

endmodule

// File: tb/tb_sort4_engine.sv
// Self-checking bench for sort4_engine: directed table, corner sequences, random batches.
module tb_sort4_engine;
    import sort4_engine_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int SW    = swap_cnt_width(DEPTH);
    localparam int LAT   = (DEPTH - 1) * (DEPTH - 1);

    typedef logic [DEPTH*WIDTH-1:0] batch_t;

    typedef struct {
        batch_t din;
        batch_t dout;
        int     swaps;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_in_valid = 1'b0;
    logic [WIDTH-1:0] i_in_data = '0;
    logic             o_in_ready;
    logic             o_out_valid;
    logic [WIDTH-1:0] o_out_data;
    logic             o_out_last;
    logic             i_out_ready = 1'b0;
    logic             o_busy;
    logic [SW-1:0]    o_swap_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sort4_engine #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .o_out_last   (o_out_last),
        .i_out_ready  (i_out_ready),
        .o_busy       (o_busy),
        .o_swap_count (o_swap_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] elem(input batch_t b, input int i);
        return b[(DEPTH-1-i)*WIDTH +: WIDTH];
    endfunction

    // Reference: ascending order via queue sort, swap count = number of inversions.
    function automatic void model(input batch_t v, output batch_t s, output int inv);
        int q[$];
        inv = 0;
        for (int i = 0; i < DEPTH; i++) q.push_back(int'(elem(v, i)));
        for (int i = 0; i < DEPTH; i++)
            for (int k = i + 1; k < DEPTH; k++)
                if (q[i] > q[k]) inv++;
        q.sort();
        s = '0;
        for (int i = 0; i < DEPTH; i++) s[(DEPTH-1-i)*WIDTH +: WIDTH] = WIDTH'(q[i]);
    endfunction

    // Feed one batch; returns #1 after the edge that accepts the last beat.
    task automatic load_batch(input batch_t v, input string nm);
        for (int i = 0; i < DEPTH; i++) begin
            int t = 0;
            i_in_valid = 1'b1;
            i_in_data  = elem(v, i);
            while (!o_in_ready && t < 100) begin
                @(posedge clk); #1; t++;
            end
            chk({nm, " in_ready"}, 32'(o_in_ready), 32'd1);
            @(posedge clk); #1;
        end
        i_in_valid = 1'b0;
    endtask

    // bp_mode: 0 = out_ready high, 1 = toggle each cycle, 2 = random.
    task automatic sort_and_drain(input batch_t exp, input int exp_sw, input string nm,
                                  input int bp_mode, input int stall, input bit hold_in);
        int cyc = 0;
        int got = 0;
        int t = 0;
        i_out_ready = 1'b0;
        if (hold_in) begin
            i_in_valid = 1'b1;
            i_in_data  = 4'hF;
        end
        chk({nm, " busy"}, 32'(o_busy), 32'd1);
        chk({nm, " in_ready in sort"}, 32'(o_in_ready), 32'd0);
        while (!o_out_valid && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        i_in_valid = 1'b0;
        chk({nm, " latency"}, 32'(cyc), 32'(LAT));
        chk({nm, " swap_count"}, 32'(o_swap_count), 32'(exp_sw));
        for (int s = 0; s < stall; s++) begin
            chk({nm, " stall data"}, 32'(o_out_data), 32'(elem(exp, 0)));
            chk({nm, " stall valid"}, 32'(o_out_valid), 32'd1);
            @(posedge clk); #1;
        end
        while (got < DEPTH && t < 200) begin
            case (bp_mode)
                0:       i_out_ready = 1'b1;
                1:       i_out_ready = t[0];
                default: i_out_ready = 1'($urandom_range(1, 0));
            endcase
            if (o_out_valid && i_out_ready) begin
                chk({nm, " data"}, 32'(o_out_data), 32'(elem(exp, got)));
                chk({nm, " last"}, 32'(o_out_last), 32'(got == DEPTH - 1));
                got++;
            end
            @(posedge clk); #1; t++;
        end
        i_out_ready = 1'b0;
        chk({nm, " pop count"}, 32'(got), 32'(DEPTH));
        chk({nm, " in_ready after"}, 32'(o_in_ready), 32'd1);
        chk({nm, " valid after"}, 32'(o_out_valid), 32'd0);
        chk({nm, " data after"}, 32'(o_out_data), 32'd0);
        chk({nm, " swap held"}, 32'(o_swap_count), 32'(exp_sw));
    endtask

    vec_t vecs[5];

    initial begin
        batch_t rv, rs;
        int     rinv;

        vecs[0] = '{din: 16'hF3A0, dout: 16'h03AF, swaps: 5};
        vecs[1] = '{din: 16'h1234, dout: 16'h1234, swaps: 0};
        vecs[2] = '{din: 16'h9751, dout: 16'h1579, swaps: 6};
        vecs[3] = '{din: 16'h9999, dout: 16'h9999, swaps: 0};
        vecs[4] = '{din: 16'h0101, dout: 16'h0011, swaps: 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(o_in_ready), 32'd1);
        chk("rst out_valid", 32'(o_out_valid), 32'd0);
        chk("rst out_data", 32'(o_out_data), 32'd0);
        chk("rst out_last", 32'(o_out_last), 32'd0);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst swap_count", 32'(o_swap_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed batches, back to back
        for (int v = 0; v < 5; v++) begin
            load_batch(vecs[v].din, $sformatf("vec%0d", v));
            sort_and_drain(vecs[v].dout, vecs[v].swaps, $sformatf("vec%0d", v), 0, 0, 1'b0);
        end

        // Backpressure: stall, toggled out_ready, in_valid held during SORT
        load_batch(16'h3021, "bp");
        sort_and_drain(16'h0123, 4, "bp", 1, 5, 1'b1);

        // Async reset in the middle of SORT
        load_batch(16'h9751, "arst");
        repeat (3) @(posedge clk);
        #1;
        chk("arst pre swap_count", 32'(o_swap_count), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst in_ready", 32'(o_in_ready), 32'd1);
        chk("arst busy", 32'(o_busy), 32'd0);
        chk("arst out_valid", 32'(o_out_valid), 32'd0);
        chk("arst swap_count", 32'(o_swap_count), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_batch(16'h2143, "post_rst");
        sort_and_drain(16'h1234, 2, "post_rst", 0, 0, 1'b0);

        // Random batches against the reference model
        for (int r = 0; r < 20; r++) begin
            rv = batch_t'($urandom);
            model(rv, rs, rinv);
            load_batch(rv, $sformatf("rnd%0d", r));
            sort_and_drain(rs, rinv, $sformatf("rnd%0d", r), 2, 0, 1'(r % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
